ham_rx_ctrl: RTL and testbench
==============================

HAM_RX_CTRL -- requirements
Module: ham_rx_ctrl

Interface
REQ-001 SHALL have parameter: ERRCNT_W, default 16, width of corrected-nibble error counter.
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: bit_in  in  1  serial Hamming bit from FSK demodulator, codeword bit 13 first.
REQ-005 SHALL have port: bit_valid  in  1  bit_in accepted on a rising edge where high.
REQ-006 SHALL have port: align  in  1  frame-start strobe, restarts codeword bit counting.
REQ-007 SHALL have port: ham_word  out  14  latched codeword, drives external Hamming decoder.
REQ-008 SHALL have port: dec_pcm  in  8  decoder corrected PCM byte, combinational from ham_word.
REQ-009 SHALL have port: dec_err  in  2  decoder per-nibble nonzero correcting syndrome, [1]=upper, [0]=lower.
REQ-010 SHALL have port: pcm_code  out  8  decoded PCM byte.
REQ-011 SHALL have port: pcm_valid  out  1  pcm_code holds an untaken byte.
REQ-012 SHALL have port: pcm_ready  in  1  consumer accepts byte.
REQ-013 SHALL have port: overrun  out  1  sticky flag, a decoded byte was dropped.
REQ-014 SHALL have port: err_cnt  out  ERRCNT_W  corrected-nibble count.

Function
REQ-015 SHALL shift bit_in into a 14-bit shift register (LSB entry) and advance a 4-bit bit counter 0..13 on each accepted bit.
REQ-016 SHALL, on the accepted bit with counter 13, latch {shift[12:0],bit_in} into ham_word, wrap the counter to 0, and move FSM SHIFT->DEC.
REQ-017 SHALL, in DEC (exactly one cycle), capture dec_pcm into pcm_code, set pcm_valid, return to SHIFT; latency 2 edges from 14th bit to pcm_valid visible.
REQ-018 SHALL keep accepting serial bits in every state; bit collection never stalls.
REQ-019 SHALL complete a transfer on an edge where pcm_valid and pcm_ready are both high; pcm_valid clears after it unless a new byte loads the same edge.
REQ-020 SHALL, in DEC with pcm_valid high and no transfer that edge, keep the old pcm_code, drop the new byte, and set overrun.
REQ-021 SHALL, in DEC with a transfer the same edge, load the new byte with pcm_valid held high, no overrun.
REQ-022 SHALL, on align high, clear the bit counter; align and bit_valid together count that bit as bit 0 (counter becomes 1).
REQ-023 SHALL NOT let align cancel a DEC cycle already entered or an output byte already held.
REQ-024 SHALL hold pcm_code stable while pcm_valid is high and not taken.
REQ-025 SHALL change ham_word only on the REQ-016 edge.

Reset
REQ-026 SHALL, on rst high at an edge, set: FSM SHIFT, bit counter 0, shift register 0, ham_word 0, pcm_code 0, pcm_valid 0, overrun 0, err_cnt 0.
REQ-027 SHALL give rst priority over all other inputs; a partial codeword in progress is discarded.
REQ-028 SHALL clear overrun only via rst.

Configuration
REQ-029 SHALL, with HAM_ERRCNT_EN defined, add popcount(dec_err) to err_cnt in each DEC cycle, including dropped bytes, saturating at all-ones.
REQ-030 SHALL, without HAM_ERRCNT_EN, tie err_cnt to 0 and have no counter logic.

Verification
REQ-031 SHALL cover: 14 bits 0x2A5B with pcm_ready=1, decoder model -> ham_word=0x2A5B after 14th edge, pcm_valid high one cycle with correct byte.
REQ-032 SHALL cover: two words back-to-back, pcm_ready=0 -> first byte held, overrun=1, second dropped; pcm_ready=1 -> first byte delivered.
REQ-033 SHALL cover: 5 bits, align pulse with bit_valid, 14 bits -> word completes on 14th post-align bit, first 5 ignored.
REQ-034 SHALL cover: rst after 9 bits, then 14 bits -> all outputs at reset values, one correct byte, no stale bits.
REQ-035 SHALL cover: HAM_ERRCNT_EN defined, words with dec_err 2'b11, 2'b01, 2'b00 -> err_cnt=3; ERRCNT_W=2 with more errors -> saturates at 3; macro undefined -> err_cnt=0.
REQ-036 SHALL cover: pcm_ready high in the DEC cycle with a byte pending -> old byte taken, new loaded, pcm_valid stays 1, overrun=0.

Source files
------------

// File: rtl/ham_rx_ctrl.sv
// ---------------------------------------------------------------------------
// HamRxCtrl (module ham_rx_ctrl)
//
// Purpose:
//    Serial-to-parallel front end for a Hamming-protected PCM link. Bits
//    arriving from the FSK demodulator are collected MSB first (codeword
//    bit 13 first) into 14-bit codewords. Each completed codeword is
//    latched onto ham_word for an external combinational Hamming decoder.
//    One cycle later, the corrected byte is captured into a single-entry
//    valid/ready output buffer. Bit collection never stalls. If the
//    buffer is still full when a new byte arrives, that byte is dropped
//    and the sticky overrun flag is raised.
//
// Configuration:
//    HAM_ERRCNT_EN - when defined, err_cnt accumulates the number of
//                    corrected nibbles reported by the decoder. The count
//                    saturates at all-ones. When the macro is undefined,
//                    err_cnt is tied to zero and no counter is built.
//
// Ports:
//    clk        in   1         rising-edge clock for all state
//    rst        in   1         synchronous active-high reset
//    bit_in     in   1         serial codeword bit, bit 13 first
//    bit_valid  in   1         bit_in is taken on edges where this is high
//    align      in   1         frame-start strobe, restarts bit counting
//    ham_word   out  14        latched codeword for the external decoder
//    dec_pcm    in   8         corrected byte from the decoder
//    dec_err    in   2         per-nibble correction flags, [1]=upper nibble
//    pcm_code   out  8         decoded byte
//    pcm_valid  out  1         pcm_code holds a byte not yet taken
//    pcm_ready  in   1         consumer takes pcm_code when high with pcm_valid
//    overrun    out  1         sticky, a decoded byte was dropped
//    err_cnt    out  ERRCNT_W  corrected-nibble counter
// ---------------------------------------------------------------------------
module ham_rx_ctrl #(
   parameter int ERRCNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bit_in,
   input  logic                bit_valid,
   input  logic                align,
   output logic [13:0]         ham_word,
   input  logic [7:0]          dec_pcm,
   input  logic [1:0]          dec_err,
   output logic [7:0]          pcm_code,
   output logic                pcm_valid,
   input  logic                pcm_ready,
   output logic                overrun,
   output logic [ERRCNT_W-1:0] err_cnt
);

   typedef enum logic {
      SHIFT = 1'b0,
      DEC   = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [13:0] shift_reg;
   logic [3:0]  bit_cnt;
   logic [3:0]  cnt_eff;
   logic        word_done;
   logic        transfer;

   // An align strobe restarts counting at zero. When align arrives together
   // with a valid bit, that bit is treated as bit 0 of the new word.
   // Because of this, the counter value seen by the incoming bit is the
   // aligned value, not the stored one.
   always_comb begin
      cnt_eff   = align ? 4'd0 : bit_cnt;
      word_done = bit_valid && (cnt_eff == 4'd13);
      transfer  = pcm_valid && pcm_ready;
   end

   // Next-state logic. DEC lasts exactly one cycle. The shortest possible
   // word takes 14 accepted bits, so a new word can never complete while
   // the FSM is still in DEC.
   always_comb begin
      state_next = state;
      case (state)
         SHIFT:   if (word_done) state_next = DEC;
         DEC:     state_next = SHIFT;
         default: state_next = SHIFT;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= SHIFT;
      else     state <= state_next;
   end

   // Serial collection runs independently of the FSM, so a slow consumer
   // can never stall the demodulator. ham_word only changes on the edge
   // that completes a word, which keeps the decoder input stable while DEC
   // samples it.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         ham_word  <= '0;
      end else if (bit_valid) begin
         shift_reg <= {shift_reg[12:0], bit_in};
         if (word_done) begin
            ham_word <= {shift_reg[12:0], bit_in};
            bit_cnt  <= 4'd0;
         end else begin
            bit_cnt  <= cnt_eff + 4'd1;
         end
      end else if (align) begin
         bit_cnt <= 4'd0;
      end
   end

   // Single-entry output buffer. In DEC, the new byte is loaded if the
   // buffer is empty or is being emptied on this same edge; pcm_valid
   // then stays high. Otherwise the held byte wins, the new byte is lost,
   // and overrun latches until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcm_code  <= '0;
         pcm_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (state == DEC) begin
         if (!pcm_valid || transfer) begin
            pcm_code  <= dec_pcm;
            pcm_valid <= 1'b1;
         end else begin
            overrun   <= 1'b1;
         end
      end else if (transfer) begin
         pcm_valid <= 1'b0;
      end
   end

   // shift_reg[13] is shifted out and never read. Only the low 13 bits
   // contribute to a completed codeword.
   logic unused_shift_msb;
   assign unused_shift_msb = shift_reg[13];

`ifdef HAM_ERRCNT_EN
   logic [1:0]        err_inc;
   logic [ERRCNT_W:0] err_sum;

   // Corrected-nibble counter. The sum is taken one bit wider so that a
   // carry out of the top bit can be detected and clamped to all-ones.
   // Dropped bytes are counted too, because the decoder still corrected
   // them.
   always_comb begin
      err_inc = {1'b0, dec_err[1]} + {1'b0, dec_err[0]};
      err_sum = {1'b0, err_cnt} + (ERRCNT_W+1)'(err_inc);
   end

   // Counter register. It only advances in DEC cycles.
   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= '0;
      else if (state == DEC)
         err_cnt <= err_sum[ERRCNT_W] ? {ERRCNT_W{1'b1}} : err_sum[ERRCNT_W-1:0];
   end
`else
   logic unused_dec_err;
   assign unused_dec_err = ^dec_err;
   assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_ham_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ham_rx_ctrl
//
// Purpose:
//    Directed bench for ham_rx_ctrl. The external Hamming decoder is
//    replaced by a stand-in that picks data bits {ham_word[13:10],
//    ham_word[6:3]}. The bench drives dec_err directly from a variable, so
//    every expected byte below is the hand-extracted value of those bit
//    positions of the transmitted word.
//
//    When the HAM_ERRCNT_EN macro is defined, a second instance with
//    ERRCNT_W=2 is also built so that counter saturation can be observed.
// ---------------------------------------------------------------------------
module tb_ham_rx_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        bit_in;
   logic        bit_valid;
   logic        align;
   logic [13:0] ham_word;
   logic [7:0]  dec_pcm;
   logic [1:0]  dec_err;
   logic [7:0]  pcm_code;
   logic        pcm_valid;
   logic        pcm_ready;
   logic        overrun;
   logic [15:0] err_cnt;
   logic [1:0]  err_pat;

   int tests_run    = 0;
   int tests_failed = 0;
   int exp_err      = 0;

   typedef struct {
      logic [13:0] word;
      logic [1:0]  err;
      logic [7:0]  exp_byte;
   } vec_t;

   vec_t vecs[5];

   ham_rx_ctrl #(.ERRCNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .align     (align),
      .ham_word  (ham_word),
      .dec_pcm   (dec_pcm),
      .dec_err   (dec_err),
      .pcm_code  (pcm_code),
      .pcm_valid (pcm_valid),
      .pcm_ready (pcm_ready),
      .overrun   (overrun),
      .err_cnt   (err_cnt)
   );

   // Stand-in decoder: pick the data bits straight from the codeword.
   assign dec_pcm = {ham_word[13:10], ham_word[6:3]};
   assign dec_err = err_pat;

`ifdef HAM_ERRCNT_EN
   logic [13:0] ham_word2;
   logic [7:0]  pcm_code2;
   logic        pcm_valid2;
   logic        overrun2;
   logic [1:0]  err_cnt2;

   ham_rx_ctrl #(.ERRCNT_W(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .align     (align),
      .ham_word  (ham_word2),
      .dec_pcm   (dec_pcm),
      .dec_err   (dec_err),
      .pcm_code  (pcm_code2),
      .pcm_valid (pcm_valid2),
      .pcm_ready (pcm_ready),
      .overrun   (overrun2),
      .err_cnt   (err_cnt2)
   );
`endif

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit past it so that
   // outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its expected value and count it.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Shift one 14-bit codeword in, bit 13 first, one bit per edge.
   // Optionally raise align together with the first bit. Returns just
   // after the 14th edge.
   task automatic applyStimulus(input logic [13:0] word, input logic with_align);
      for (int i = 13; i >= 0; i--) begin
         bit_in    = word[i];
         bit_valid = 1'b1;
         align     = with_align && (i == 13);
         tick();
      end
      bit_valid = 1'b0;
      align     = 1'b0;
   endtask

   // Synchronous reset for one edge.
   task automatic doReset();
      rst       = 1'b1;
      bit_valid = 1'b0;
      align     = 1'b0;
      tick();
      rst       = 1'b0;
      exp_err   = 0;
   endtask

   initial begin
      vecs[0] = '{word: 14'h2A5B, err: 2'b11, exp_byte: 8'hAB};
      vecs[1] = '{word: 14'h1234, err: 2'b01, exp_byte: 8'h46};
      vecs[2] = '{word: 14'h15A6, err: 2'b00, exp_byte: 8'h54};
      vecs[3] = '{word: 14'h3FFF, err: 2'b10, exp_byte: 8'hFF};
      vecs[4] = '{word: 14'h0000, err: 2'b00, exp_byte: 8'h00};

      rst       = 1'b1;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      align     = 1'b0;
      pcm_ready = 1'b0;
      err_pat   = 2'b00;

      // Reset state.
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset ham_word",  32'(ham_word),  32'h0);
      checkOutput("reset pcm_code",  32'(pcm_code),  32'h0);
      checkOutput("reset pcm_valid", 32'(pcm_valid), 32'h0);
      checkOutput("reset overrun",   32'(overrun),   32'h0);
      checkOutput("reset err_cnt",   32'(err_cnt),   32'h0);

      // Table: one word at a time, consumer always ready.
      pcm_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         err_pat = vecs[v].err;
         applyStimulus(vecs[v].word, 1'b0);
         checkOutput("tbl ham_word", 32'(ham_word), 32'(vecs[v].word));
         checkOutput("tbl latency valid low", 32'(pcm_valid), 32'h0);
         tick();
         exp_err += $countones(vecs[v].err);
         err_pat = 2'b00;
         checkOutput("tbl pcm_valid", 32'(pcm_valid), 32'h1);
         checkOutput("tbl pcm_code", 32'(pcm_code), 32'(vecs[v].exp_byte));
         tick();
         checkOutput("tbl valid one cycle", 32'(pcm_valid), 32'h0);
      end
      checkOutput("tbl overrun", 32'(overrun), 32'h0);
`ifdef HAM_ERRCNT_EN
      checkOutput("err_cnt sum", 32'(err_cnt), 32'(exp_err));
      checkOutput("err_cnt sat", 32'(err_cnt2), 32'h3);
`else
      checkOutput("err_cnt tied", 32'(err_cnt), 32'h0);
`endif

      // Back-to-back words with the consumer stalled: first byte held,
      // second dropped, overrun raised and sticky.
      doReset();
      pcm_ready = 1'b0;
      applyStimulus(14'h2A5B, 1'b0);
      applyStimulus(14'h1234, 1'b0);
      checkOutput("b2b ham_word", 32'(ham_word), 32'h1234);
      checkOutput("b2b first held valid", 32'(pcm_valid), 32'h1);
      checkOutput("b2b no overrun yet", 32'(overrun), 32'h0);
      tick();
      checkOutput("b2b pcm_code held", 32'(pcm_code), 32'hAB);
      checkOutput("b2b overrun", 32'(overrun), 32'h1);
      pcm_ready = 1'b1;
      tick();
      checkOutput("b2b delivered", 32'(pcm_valid), 32'h0);
      checkOutput("b2b overrun sticky", 32'(overrun), 32'h1);
      doReset();
      checkOutput("overrun cleared", 32'(overrun), 32'h0);

      // Align: five stray bits, then a word whose first bit carries align.
      bit_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bit_in = 1'b1;
         tick();
      end
      bit_valid = 1'b0;
      applyStimulus(14'h15A6, 1'b1);
      checkOutput("align ham_word", 32'(ham_word), 32'h15A6);
      tick();
      checkOutput("align pcm_valid", 32'(pcm_valid), 32'h1);
      checkOutput("align pcm_code", 32'(pcm_code), 32'h54);
      tick();

      // Reset mid-word discards the partial codeword.
      bit_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bit_in = 1'(i % 2);
         tick();
      end
      doReset();
      checkOutput("midrst ham_word",  32'(ham_word),  32'h0);
      checkOutput("midrst pcm_code",  32'(pcm_code),  32'h0);
      checkOutput("midrst pcm_valid", 32'(pcm_valid), 32'h0);
      checkOutput("midrst err_cnt",   32'(err_cnt),   32'h0);
      applyStimulus(14'h1234, 1'b0);
      checkOutput("midrst new word", 32'(ham_word), 32'h1234);
      tick();
      checkOutput("midrst byte", 32'(pcm_code), 32'h46);
      checkOutput("midrst valid", 32'(pcm_valid), 32'h1);
      tick();

      // A take in the DEC cycle makes room for the new byte.
      doReset();
      pcm_ready = 1'b0;
      applyStimulus(14'h2A5B, 1'b0);
      applyStimulus(14'h3FFF, 1'b0);
      checkOutput("dectake old code", 32'(pcm_code), 32'hAB);
      pcm_ready = 1'b1;
      tick();
      checkOutput("dectake valid stays", 32'(pcm_valid), 32'h1);
      checkOutput("dectake new code", 32'(pcm_code), 32'hFF);
      checkOutput("dectake no overrun", 32'(overrun), 32'h0);
      tick();
      checkOutput("dectake drained", 32'(pcm_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
